// File: rtl/cnn_accel_pkg.sv
// Shared definitions for the CNN accelerator address path: width defaults and
// the address-generator state encoding (4 bits, matching the memory-state field).
// Latency: n/a (package).  Backpressure: n/a (package).
package cnn_accel_pkg;

  localparam int ADDRESS_BUS_BIT_WIDTH = 32;
  localparam int DIM_BIT_WIDTH         = 8;
  localparam int KERNEL_BIT_WIDTH      = 4;
  localparam int STRIDE_BIT_WIDTH      = 2;

  localparam int AG_STATE_BIT_WIDTH    = 4;

  typedef enum logic [AG_STATE_BIT_WIDTH-1:0] {
    AG_IDLE   = 4'd0,
    AG_READ   = 4'd1,
    AG_FINISH = 4'd2,
    AG_DONE   = 4'd3
  } ag_state_e;

endpackage

// File: rtl/window_tap_counter.sv
// Walks the K x K kernel window of one output pixel, keeping kr/kc and the
// current tap word address; pointer-only arithmetic (adds of 1 and in_width).
// Latency: tap address registered, valid the cycle after load/advance.  Backpressure: holds while advance_i low.
//
// Ports:
//   clk, layer_reset_n   clock, async active-low reset
//   load_i, origin_i     restart the window at origin_i (window top-left address)
//   in_width_i           input row length, added per kernel row
//   kernel_size_i        K (non-zero whenever the window is in use)
//   advance_i            current tap accepted, step to the next one
//   tap_ptr_o            current tap address
//   last_tap_o           current tap is (K-1, K-1)
module window_tap_counter #(
  parameter int ADDRESS_BUS_BIT_WIDTH = cnn_accel_pkg::ADDRESS_BUS_BIT_WIDTH,
  parameter int DIM_BIT_WIDTH         = cnn_accel_pkg::DIM_BIT_WIDTH,
  parameter int KERNEL_BIT_WIDTH      = cnn_accel_pkg::KERNEL_BIT_WIDTH
) (
  input  logic                             clk,
  input  logic                             layer_reset_n,
  input  logic                             load_i,
  input  logic [ADDRESS_BUS_BIT_WIDTH-1:0] origin_i,
  input  logic [DIM_BIT_WIDTH-1:0]         in_width_i,
  input  logic [KERNEL_BIT_WIDTH-1:0]      kernel_size_i,
  input  logic                             advance_i,
  output logic [ADDRESS_BUS_BIT_WIDTH-1:0] tap_ptr_o,
  output logic                             last_tap_o
);

  logic [KERNEL_BIT_WIDTH-1:0]      kr_q, kr_d;
  logic [KERNEL_BIT_WIDTH-1:0]      kc_q, kc_d;
  logic [KERNEL_BIT_WIDTH-1:0]      k_last;
  logic [ADDRESS_BUS_BIT_WIDTH-1:0] win_row_ptr_q, win_row_ptr_d;
  logic [ADDRESS_BUS_BIT_WIDTH-1:0] tap_ptr_q, tap_ptr_d;
  logic [ADDRESS_BUS_BIT_WIDTH-1:0] next_row_ptr;

  assign k_last       = kernel_size_i - KERNEL_BIT_WIDTH'(1);
  assign next_row_ptr = win_row_ptr_q + ADDRESS_BUS_BIT_WIDTH'(in_width_i);
  assign last_tap_o   = (kr_q == k_last) && (kc_q == k_last);
  assign tap_ptr_o    = tap_ptr_q;

  always_comb begin
    kr_d          = kr_q;
    kc_d          = kc_q;
    win_row_ptr_d = win_row_ptr_q;
    tap_ptr_d     = tap_ptr_q;
    if (load_i) begin
      kr_d          = '0;
      kc_d          = '0;
      win_row_ptr_d = origin_i;
      tap_ptr_d     = origin_i;
    end else if (advance_i) begin
      if (kc_q == k_last) begin
        // Next kernel row: the row pointer steps by one input row and the tap
        // restarts at its first column. After the last tap kr runs one past
        // K-1; harmless, the window is reloaded before it is read again.
        kc_d          = '0;
        kr_d          = kr_q + KERNEL_BIT_WIDTH'(1);
        win_row_ptr_d = next_row_ptr;
        tap_ptr_d     = next_row_ptr;
      end else begin
        kc_d      = kc_q + KERNEL_BIT_WIDTH'(1);
        tap_ptr_d = tap_ptr_q + ADDRESS_BUS_BIT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      kr_q          <= '0;
      kc_q          <= '0;
      win_row_ptr_q <= '0;
      tap_ptr_q     <= '0;
    end else begin
      kr_q          <= kr_d;
      kc_q          <= kc_d;
      win_row_ptr_q <= win_row_ptr_d;
      tap_ptr_q     <= tap_ptr_d;
    end
  end

endmodule

// File: rtl/conv_address_generator.sv
// Per layer, walks every output pixel and each of its K x K kernel taps, emitting
// read addresses, then one write address with a stage-finish pulse per pixel.
// Latency: first read the cycle after start; K*K+1 cycles per pixel minimum.  Backpressure: rd_ready_i low stalls address and counters.
//
// Ports:
//   clk, layer_reset_n            clock, async active-low reset (aborts the layer)
//   start_i + config inputs       config sampled only on the accepted start (IDLE)
//   rd_ready_i                    sequencer accepts read_address_o
//   read_address_o / rd_valid_o   current tap address, valid in READ
//   write_address_o               output address of the pixel just completed
//   stage_finish_o                one-cycle pulse after the last tap of a pixel
//   busy_o, done_o                layer in progress / one-cycle layer complete
module conv_address_generator #(
  parameter int ADDRESS_BUS_BIT_WIDTH = cnn_accel_pkg::ADDRESS_BUS_BIT_WIDTH,
  parameter int DIM_BIT_WIDTH         = cnn_accel_pkg::DIM_BIT_WIDTH,
  parameter int KERNEL_BIT_WIDTH      = cnn_accel_pkg::KERNEL_BIT_WIDTH,
  parameter int STRIDE_BIT_WIDTH      = cnn_accel_pkg::STRIDE_BIT_WIDTH
) (
  input  logic                             clk,
  input  logic                             layer_reset_n,
  input  logic                             start_i,
  input  logic [ADDRESS_BUS_BIT_WIDTH-1:0] in_base_i,
  input  logic [ADDRESS_BUS_BIT_WIDTH-1:0] out_base_i,
  input  logic [DIM_BIT_WIDTH-1:0]         in_width_i,
  input  logic [DIM_BIT_WIDTH-1:0]         out_height_i,
  input  logic [DIM_BIT_WIDTH-1:0]         out_width_i,
  input  logic [KERNEL_BIT_WIDTH-1:0]      kernel_size_i,
  input  logic [STRIDE_BIT_WIDTH-1:0]      stride_i,
  input  logic                             rd_ready_i,
  output logic [ADDRESS_BUS_BIT_WIDTH-1:0] read_address_o,
  output logic                             rd_valid_o,
  output logic [ADDRESS_BUS_BIT_WIDTH-1:0] write_address_o,
  output logic                             stage_finish_o,
  output logic                             busy_o,
  output logic                             done_o
);

  import cnn_accel_pkg::*;

  localparam int AW = ADDRESS_BUS_BIT_WIDTH;

  ag_state_e                   state_q;

  // Latched layer configuration
  logic [DIM_BIT_WIDTH-1:0]    in_width_q;
  logic [DIM_BIT_WIDTH-1:0]    out_height_q;
  logic [DIM_BIT_WIDTH-1:0]    out_width_q;
  logic [KERNEL_BIT_WIDTH-1:0] kernel_q;
  logic [STRIDE_BIT_WIDTH-1:0] stride_q;
  logic [AW-1:0]               row_step_q;   // S * in_width, one output row down

  // Output-pixel position and incremental pointers
  logic [DIM_BIT_WIDTH-1:0]    row_q, col_q;
  logic [AW-1:0]               row_ptr_q;    // window origin of column 0 of this row
  logic [AW-1:0]               pix_ptr_q;    // window origin of the current pixel
  logic [AW-1:0]               out_ptr_q;    // output address of the current pixel

  // Registered outputs
  logic                        rd_valid_q;
  logic                        stage_finish_q;
  logic                        busy_q;
  logic                        done_q;
  logic [AW-1:0]               write_address_q;

  logic [AW-1:0]               row_step_in;
  logic                        cfg_empty;
  logic                        last_col, last_row;
  logic [AW-1:0]               next_pix_ptr;
  logic                        tc_load, tc_advance, tc_last;
  logic [AW-1:0]               tc_origin, tc_tap_ptr;

  // S * in_width by shift-and-add over the few stride bits.
  always_comb begin
    row_step_in = '0;
    for (int b = 0; b < STRIDE_BIT_WIDTH; b++) begin
      if (stride_i[b]) begin
        row_step_in = row_step_in + (AW'(in_width_i) << b);
      end
    end
  end

  assign cfg_empty = (out_height_i == '0) || (out_width_i == '0) || (kernel_size_i == '0);
  assign last_col  = (col_q == out_width_q - DIM_BIT_WIDTH'(1));
  assign last_row  = (row_q == out_height_q - DIM_BIT_WIDTH'(1));

  // Next pixel's window origin: either one stride right, or the start of the
  // next output row (which is one row_step below the current row start).
  assign next_pix_ptr = last_col ? (row_ptr_q + row_step_q)
                                 : (pix_ptr_q + AW'(stride_q));

  always_comb begin
    tc_load   = 1'b0;
    tc_origin = next_pix_ptr;
    if (state_q == AG_IDLE && start_i && !cfg_empty) begin
      tc_load   = 1'b1;
      tc_origin = in_base_i;
    end else if (state_q == AG_FINISH && !(last_col && last_row)) begin
      tc_load   = 1'b1;
    end
  end

  assign tc_advance = (state_q == AG_READ) && rd_ready_i;

  window_tap_counter #(
    .ADDRESS_BUS_BIT_WIDTH (ADDRESS_BUS_BIT_WIDTH),
    .DIM_BIT_WIDTH         (DIM_BIT_WIDTH),
    .KERNEL_BIT_WIDTH      (KERNEL_BIT_WIDTH)
  ) u_window_tap_counter (
    .clk           (clk),
    .layer_reset_n (layer_reset_n),
    .load_i        (tc_load),
    .origin_i      (tc_origin),
    .in_width_i    (in_width_q),
    .kernel_size_i (kernel_q),
    .advance_i     (tc_advance),
    .tap_ptr_o     (tc_tap_ptr),
    .last_tap_o    (tc_last)
  );

  // Tap counter keeps its last pointer outside READ; gate so the port idles at 0.
  assign read_address_o  = rd_valid_q ? tc_tap_ptr : '0;
  assign rd_valid_o      = rd_valid_q;
  assign write_address_o = write_address_q;
  assign stage_finish_o  = stage_finish_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      state_q         <= AG_IDLE;
      in_width_q      <= '0;
      out_height_q    <= '0;
      out_width_q     <= '0;
      kernel_q        <= '0;
      stride_q        <= '0;
      row_step_q      <= '0;
      row_q           <= '0;
      col_q           <= '0;
      row_ptr_q       <= '0;
      pix_ptr_q       <= '0;
      out_ptr_q       <= '0;
      rd_valid_q      <= 1'b0;
      stage_finish_q  <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      write_address_q <= '0;
    end else begin
      case (state_q)
        AG_IDLE: begin
          if (start_i) begin
            in_width_q   <= in_width_i;
            out_height_q <= out_height_i;
            out_width_q  <= out_width_i;
            kernel_q     <= kernel_size_i;
            stride_q     <= stride_i;
            row_step_q   <= row_step_in;
            row_q        <= '0;
            col_q        <= '0;
            row_ptr_q    <= in_base_i;
            pix_ptr_q    <= in_base_i;
            out_ptr_q    <= out_base_i;
            if (cfg_empty) begin
              // Nothing to walk: report completion without ever going busy.
              state_q <= AG_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= AG_READ;
              rd_valid_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end

        AG_READ: begin
          if (rd_ready_i && tc_last) begin
            state_q         <= AG_FINISH;
            rd_valid_q      <= 1'b0;
            stage_finish_q  <= 1'b1;
            write_address_q <= out_ptr_q;
          end
        end

        AG_FINISH: begin
          stage_finish_q <= 1'b0;
          // Output map is row-major and dense, so the write pointer just counts.
          out_ptr_q      <= out_ptr_q + AW'(1);
          if (last_col && last_row) begin
            state_q <= AG_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q    <= AG_READ;
            rd_valid_q <= 1'b1;
            pix_ptr_q  <= next_pix_ptr;
            if (last_col) begin
              col_q     <= '0;
              row_q     <= row_q + DIM_BIT_WIDTH'(1);
              row_ptr_q <= row_ptr_q + row_step_q;
            end else begin
              col_q <= col_q + DIM_BIT_WIDTH'(1);
            end
          end
        end

        AG_DONE: begin
          done_q  <= 1'b0;
          state_q <= AG_IDLE;
        end

        default: begin
          state_q        <= AG_IDLE;
          rd_valid_q     <= 1'b0;
          stage_finish_q <= 1'b0;
          busy_q         <= 1'b0;
          done_q         <= 1'b0;
        end
      endcase
    end
  end

endmodule
